processor_no_mem: RTL and testbench
===================================

// Module: processor_no_mem
// PURPOSE
//  RV32I integer core with no instruction or data memory. The core receives each instruction directly on `command`.
//  It executes one instruction per 4-cycle multicycle pass and exposes its full architectural/debug state on `regValues`.
//  Top-level bring-up block; a later revision adds memory.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
// PORTS
//  clk        in   1         single clock; all state updates on posedge
//  reset      in   1         synchronous, active-high reset
//  command    in   32        instruction word, RV32I encoding; must be stable from FETCH edge
//  run        in   1         reserved; tie low; no effect this revision (core free-runs out of reset)
//  done       out  1         one-cycle pulse: instruction retired, regValues updated
//  regValues  out  39x32 s   [0..31]=x0..x31, [32]=PC, [33]=IR, [34]=imm, [35]=ALU A, [36]=ALU B, [37]=ALU result, [38]={29'b0,state}
// BEHAVIOUR
//  Reset (clk edge with reset=1):
//   - all x-regs, IR, imm, ALU regs := 0; PC := RESET_PC
//   - state := FETCH; done := 0
//   - reset has priority and aborts any in-flight instruction with no writeback
//  FSM, one state per clk (4 cycles/instr):
//   - FETCH: IR <= command
//   - DECODE: imm, rs1/rs2 reads -> A/B
//   - EXECUTE: ALU result
//   - WRITEBACK: rd and PC update, done <= 1; next state FETCH
//  done is 1 only in the cycle after the WRITEBACK edge; 0 otherwise.
//  Result of a command applied before a FETCH edge is visible on regValues 4 edges later.
//  x0 is hardwired 0; writes with rd=0 are discarded.
//  Immediates are sign-extended to 32 bits per RV32I I/S/B/U/J formats.
//  OP_IMM (0010011): ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI
//   - shamt = imm[4:0]; SRAI selected by funct7=0100000
//  OP (0110011): ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
//   - funct7=0100000 selects SUB/SRA; SUB = rs1 - rs2
//   - shift amount = rs2[4:0]
//  SLT/SLTI compare signed; SLTU/SLTIU compare unsigned; result 0 or 1.
//  All arithmetic wraps modulo 2^32; no overflow trap.
//  LUI: rd = imm_U<<12. AUIPC: rd = PC + (imm_U<<12).
//  JAL: rd = PC+4; PC = PC+imm_J. JALR: rd = PC+4; PC = (rs1+imm_I) & ~1.
//  BRANCH: BEQ BNE BLT BGE BLTU BGEU; taken -> PC += imm_B, else PC += 4.
//  All other instructions, including LOAD/STORE, FENCE and SYSTEM:
//   - execute as NOP: no register write, PC += 4, done still pulses
//  Non-jump, non-branch instructions: PC += 4 in WRITEBACK.
//  Same rs and rd (e.g. ADD x1,x1,x1): operands are read in DECODE, so old values are used.
// TESTING
//  - reset 2 cycles, ADDI x1,x0,10 -> x1=10; PC=4; done pulses once after 4 edges
//  - ADDI x2,x0,0xFFC -> x2=-4. ADD x3,x1,x2 -> 6. SUB x4,x1,x2 -> 14. SUB x4,x2,x1 -> -14
//  - SLT x5,x2,x1 -> 1; SLTU x6,x0,x2 -> 1; AND x7,x1,x3 -> 2; OR x8,x1,x3 -> 14; XOR x9,x1,x3 -> 12
//  - shifts with x2=-4, x7=2:
//    - SLL x10,x2,x7 -> -16
//    - SRL x11,x2,x7 -> 1073741823
//    - SRA x12,x2,x7 -> -1
//  - ADDI x0,x0,5 -> x0 stays 0; LUI x13,0x12345 -> 0x12345000; JAL x1,+8 at PC=0x30 -> x1=0x34, PC=0x38
//  - BEQ taken/not-taken -> PC+imm_B / PC+4; reset asserted mid-EXECUTE -> no rd write, state=FETCH, PC=RESET_PC

Source files
------------

// File: rtl/processor_no_mem.sv
// processor_no_mem: RV32I integer core without instruction or data memory.
// Each instruction arrives on `command` and runs through a fixed 4-cycle
// FETCH/DECODE/EXECUTE/WRITEBACK pass. The architectural and debug state is
// exposed on regValues.
module processor_no_mem #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] command,
  input  logic        run,
  output logic        done,
  output logic [31:0] regValues [0:38]
);

  localparam logic [2:0] FETCH     = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] EXECUTE   = 3'd2;
  localparam logic [2:0] WRITEBACK = 3'd3;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic [2:0]  state;
  logic [31:0] xreg [0:31];
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic        alt;

  logic [31:0] imm_dec;
  logic [31:0] opa_dec;
  logic [31:0] opb_dec;
  logic [31:0] alu_next;
  logic [31:0] sra_res;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] wb_data;
  logic        wb_en;

  // run is reserved in this revision; the core free-runs out of reset
  logic        unused_run;
  assign unused_run = run;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign funct3   = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign alt      = ir[30];
  assign pc_plus4 = pc + 32'd4;

  // Immediate generation: sign-extended I/S/B/U/J formats selected by opcode
  always_comb begin
    imm_dec = {{20{ir[31]}}, ir[31:20]};
    case (opcode)
      OPC_STORE:             imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH:            imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:    imm_dec = {ir[31:12], 12'b0};
      OPC_JAL:               imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:               imm_dec = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  // Operand selection: PC-relative forms use PC as A; LUI adds to zero;
  // register-register and branch forms take rs2 as B, everything else the immediate
  always_comb begin
    opa_dec = xreg[rs1];
    opb_dec = imm_dec;
    case (opcode)
      OPC_AUIPC, OPC_JAL: opa_dec = pc;
      OPC_LUI:            opa_dec = '0;
      default:            opa_dec = xreg[rs1];
    endcase
    if (opcode == OPC_OP || opcode == OPC_BRANCH) begin
      opb_dec = xreg[rs2];
    end
  end

  // ALU: arithmetic/logic for OP and OP_IMM, branch condition (0/1) for
  // BRANCH, plain addition for address/upper-immediate forms
  always_comb begin
    sra_res  = $signed(alu_a) >>> alu_b[4:0];
    alu_next = alu_a + alu_b;
    if (opcode == OPC_BRANCH) begin
      case (funct3)
        3'b000:  alu_next = {31'b0, alu_a == alu_b};
        3'b001:  alu_next = {31'b0, alu_a != alu_b};
        3'b100:  alu_next = {31'b0, $signed(alu_a) < $signed(alu_b)};
        3'b101:  alu_next = {31'b0, $signed(alu_a) >= $signed(alu_b)};
        3'b110:  alu_next = {31'b0, alu_a < alu_b};
        3'b111:  alu_next = {31'b0, alu_a >= alu_b};
        default: alu_next = '0;
      endcase
    end else if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
      case (funct3)
        3'b000:  alu_next = (opcode == OPC_OP && alt) ? alu_a - alu_b : alu_a + alu_b;
        3'b001:  alu_next = alu_a << alu_b[4:0];
        3'b010:  alu_next = {31'b0, $signed(alu_a) < $signed(alu_b)};
        3'b011:  alu_next = {31'b0, alu_a < alu_b};
        3'b100:  alu_next = alu_a ^ alu_b;
        3'b101:  alu_next = alt ? sra_res : alu_a >> alu_b[4:0];
        3'b110:  alu_next = alu_a | alu_b;
        default: alu_next = alu_a & alu_b;
      endcase
    end
  end

  // Writeback selection: destination data, write enable and next PC
  always_comb begin
    wb_en   = 1'b0;
    wb_data = alu_y;
    pc_next = pc_plus4;
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: wb_en = 1'b1;
      OPC_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        pc_next = alu_y;
      end
      OPC_JALR: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        pc_next = {alu_y[31:1], 1'b0};
      end
      OPC_BRANCH: pc_next = alu_y[0] ? pc + imm : pc_plus4;
      default: ;
    endcase
  end

  // Multicycle sequencer and all architectural state; reset aborts any pass
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      done  <= 1'b0;
      pc    <= RESET_PC;
      ir    <= '0;
      imm   <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_y <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        xreg[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        FETCH: begin
          ir    <= command;
          state <= DECODE;
        end
        DECODE: begin
          imm   <= imm_dec;
          alu_a <= opa_dec;
          alu_b <= opb_dec;
          state <= EXECUTE;
        end
        EXECUTE: begin
          alu_y <= alu_next;
          state <= WRITEBACK;
        end
        WRITEBACK: begin
          if (wb_en && rd != 5'd0) begin
            xreg[rd] <= wb_data;
          end
          pc    <= pc_next;
          done  <= 1'b1;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Debug view of the complete core state
  always_comb begin
    for (int unsigned i = 0; i < 32; i++) begin
      regValues[i] = xreg[i];
    end
    regValues[32] = pc;
    regValues[33] = ir;
    regValues[34] = imm;
    regValues[35] = alu_a;
    regValues[36] = alu_b;
    regValues[37] = alu_y;
    regValues[38] = {29'b0, state};
  end

endmodule

// File: tb/tb_processor_no_mem.sv
// Self-checking bench for processor_no_mem: directed RV32I scenarios plus a
// randomized instruction stream compared against an instruction-level model.
module tb_processor_no_mem;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [31:0] command = NOP;
  logic        done;
  logic [31:0] regValues [0:38];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_x [0:31];
  logic [31:0] m_pc;

  processor_no_mem #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .command(command), .run(run),
    .done(done), .regValues(regValues)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] sext_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] sext_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] sext_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] calc(input logic [2:0] f3, input logic neg_or_arith,
                                       input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    case (f3)
      3'd0: r = neg_or_arith ? x - y : x + y;
      3'd1: r = x << y[4:0];
      3'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: r = (x < y) ? 32'd1 : 32'd0;
      3'd4: r = x ^ y;
      3'd5: if (neg_or_arith) r = $signed(x) >>> y[4:0]; else r = x >> y[4:0];
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd4: return $signed(x) < $signed(y);
      3'd5: return $signed(x) >= $signed(y);
      3'd6: return x < y;
      3'd7: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_x[i] = '0;
    m_pc = RST_PC;
  endtask

  task automatic model_exec(input logic [31:0] ins);
    logic [31:0] a, b, res, nxt;
    logic wr;
    logic [4:0] rd;
    logic [2:0] f3;
    a   = m_x[ins[19:15]];
    b   = m_x[ins[24:20]];
    rd  = ins[11:7];
    f3  = ins[14:12];
    nxt = m_pc + 32'd4;
    res = '0;
    wr  = 1'b0;
    case (ins[6:0])
      7'b0010011: begin wr = 1'b1; res = calc(f3, (f3 == 3'd5) && ins[30], a, sext_i(ins)); end
      7'b0110011: begin wr = 1'b1; res = calc(f3, ins[30], a, b); end
      7'b0110111: begin wr = 1'b1; res = {ins[31:12], 12'b0}; end
      7'b0010111: begin wr = 1'b1; res = m_pc + {ins[31:12], 12'b0}; end
      7'b1101111: begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + sext_j(ins); end
      7'b1100111: begin wr = 1'b1; res = m_pc + 32'd4; nxt = (a + sext_i(ins)) & ~32'd1; end
      7'b1100011: if (taken(f3, a, b)) nxt = m_pc + sext_b(ins);
      default: ;
    endcase
    if (wr && rd != 5'd0) m_x[rd] = res;
    m_pc = nxt;
  endtask

  // Apply one instruction at the FETCH edge, check done over its four edges,
  // then compare the whole architectural state against the model.
  task automatic run_instr(input logic [31:0] ins);
    logic exp_done;
    command = ins;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      exp_done = (e == 4);
      vectors++;
      if (done !== exp_done) begin
        miscompares++;
        $display("FAIL done edge%0d ins=%h got %b want %b", e, ins, done, exp_done);
      end
    end
    model_exec(ins);
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (regValues[i] !== m_x[i]) begin
        miscompares++;
        $display("FAIL x%0d ins=%h got %h want %h", i, ins, regValues[i], m_x[i]);
      end
    end
    vectors++;
    if (regValues[32] !== m_pc) begin
      miscompares++;
      $display("FAIL pc ins=%h got %h want %h", ins, regValues[32], m_pc);
    end
    vectors++;
    if (regValues[33] !== ins) begin
      miscompares++;
      $display("FAIL ir got %h want %h", regValues[33], ins);
    end
    vectors++;
    if (regValues[38] !== 32'd0) begin
      miscompares++;
      $display("FAIL state_after_wb ins=%h got %h want 0", ins, regValues[38]);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    command = NOP;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (regValues[i] !== 32'd0) begin
        miscompares++; $display("FAIL reset_x%0d got %h want 0", i, regValues[i]);
      end
    end
    vectors++;
    if (regValues[32] !== RST_PC) begin miscompares++; $display("FAIL reset_pc got %h want %h", regValues[32], RST_PC); end
    for (int i = 33; i < 38; i++) begin
      vectors++;
      if (regValues[i] !== 32'd0) begin
        miscompares++; $display("FAIL reset_dbg%0d got %h want 0", i, regValues[i]);
      end
    end
    vectors++;
    if (regValues[38] !== 32'd0) begin miscompares++; $display("FAIL reset_state got %h want 0", regValues[38]); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_arith();
    run_instr(enc_i(12'd10, 5'd0, 3'd0, 5'd1, 7'b0010011));
    vectors++;
    if (regValues[1] !== 32'd10 || regValues[32] !== 32'd4) begin
      miscompares++; $display("FAIL addi_x1 got x1=%h pc=%h want 0000000a/00000004", regValues[1], regValues[32]);
    end
    run_instr(enc_i(12'hFFC, 5'd0, 3'd0, 5'd2, 7'b0010011));
    vectors++;
    if (regValues[2] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL addi_neg got %h want fffffffc", regValues[2]); end
    run_instr(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011));
    vectors++;
    if (regValues[3] !== 32'd6) begin miscompares++; $display("FAIL add got %h want 6", regValues[3]); end
    run_instr(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'b0110011));
    vectors++;
    if (regValues[4] !== 32'd14) begin miscompares++; $display("FAIL sub got %h want e", regValues[4]); end
    run_instr(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4, 7'b0110011));
    vectors++;
    if (regValues[4] !== 32'hFFFF_FFF2) begin miscompares++; $display("FAIL sub_neg got %h want fffffff2", regValues[4]); end
  endtask

  task automatic test_logic();
    run_instr(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5, 7'b0110011));
    run_instr(enc_r(7'h00, 5'd2, 5'd0, 3'd3, 5'd6, 7'b0110011));
    run_instr(enc_r(7'h00, 5'd3, 5'd1, 3'd7, 5'd7, 7'b0110011));
    run_instr(enc_r(7'h00, 5'd3, 5'd1, 3'd6, 5'd8, 7'b0110011));
    run_instr(enc_r(7'h00, 5'd3, 5'd1, 3'd4, 5'd9, 7'b0110011));
    vectors++;
    if (regValues[5] !== 32'd1 || regValues[6] !== 32'd1 || regValues[7] !== 32'd2 ||
        regValues[8] !== 32'd14 || regValues[9] !== 32'd12) begin
      miscompares++;
      $display("FAIL logic got slt=%h sltu=%h and=%h or=%h xor=%h want 1/1/2/e/c",
               regValues[5], regValues[6], regValues[7], regValues[8], regValues[9]);
    end
  endtask

  task automatic test_shift();
    run_instr(enc_r(7'h00, 5'd7, 5'd2, 3'd1, 5'd10, 7'b0110011));
    run_instr(enc_r(7'h00, 5'd7, 5'd2, 3'd5, 5'd11, 7'b0110011));
    run_instr(enc_r(7'h20, 5'd7, 5'd2, 3'd5, 5'd12, 7'b0110011));
    vectors++;
    if (regValues[10] !== 32'hFFFF_FFF0 || regValues[11] !== 32'h3FFF_FFFF || regValues[12] !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL shift got sll=%h srl=%h sra=%h want fffffff0/3fffffff/ffffffff",
               regValues[10], regValues[11], regValues[12]);
    end
  endtask

  task automatic test_x0_lui();
    run_instr(enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'b0010011));
    vectors++;
    if (regValues[0] !== 32'd0) begin miscompares++; $display("FAIL x0_write got %h want 0", regValues[0]); end
    run_instr(enc_u(20'h12345, 5'd13, 7'b0110111));
    vectors++;
    if (regValues[13] !== 32'h1234_5000) begin miscompares++; $display("FAIL lui got %h want 12345000", regValues[13]); end
  endtask

  task automatic test_jump();
    logic [31:0] off;
    off = 32'h30 - m_pc;
    run_instr(enc_j(off[20:0], 5'd0));
    run_instr(enc_j(21'd8, 5'd1));
    vectors++;
    if (regValues[1] !== 32'h34 || regValues[32] !== 32'h38) begin
      miscompares++; $display("FAIL jal got x1=%h pc=%h want 00000034/00000038", regValues[1], regValues[32]);
    end
    run_instr(enc_i(12'd3, 5'd1, 3'd0, 5'd5, 7'b1100111));
    vectors++;
    if (regValues[5] !== 32'h3C || regValues[32] !== 32'h36) begin
      miscompares++; $display("FAIL jalr got x5=%h pc=%h want 0000003c/00000036", regValues[5], regValues[32]);
    end
  endtask

  task automatic test_branch();
    logic [31:0] p;
    p = m_pc;
    run_instr(enc_b(13'd16, 5'd1, 5'd1, 3'd0));
    vectors++;
    if (regValues[32] !== p + 32'd16) begin
      miscompares++; $display("FAIL beq_taken got %h want %h", regValues[32], p + 32'd16);
    end
    p = m_pc;
    run_instr(enc_b(13'd16, 5'd0, 5'd1, 3'd0));
    vectors++;
    if (regValues[32] !== p + 32'd4) begin
      miscompares++; $display("FAIL beq_not_taken got %h want %h", regValues[32], p + 32'd4);
    end
  endtask

  task automatic test_nop_classes();
    run_instr(enc_i(12'd4, 5'd1, 3'd2, 5'd20, 7'b0000011));
    run_instr(enc_r(7'h00, 5'd3, 5'd1, 3'd2, 5'd4, 7'b0100011));
    run_instr(32'h0FF0_000F);
    run_instr(32'h0000_0073);
  endtask

  task automatic test_reset_mid();
    command = enc_i(12'd99, 5'd0, 3'd0, 5'd15, 7'b0010011);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (regValues[38] !== 32'd2) begin miscompares++; $display("FAIL mid_state_pre got %h want 2", regValues[38]); end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (regValues[38] !== 32'd0 || regValues[32] !== RST_PC) begin
      miscompares++; $display("FAIL mid_reset got state=%h pc=%h want 0/%h", regValues[38], regValues[32], RST_PC);
    end
    @(posedge clk); #1;
    vectors++;
    if (regValues[15] !== 32'd0 || done !== 1'b0) begin
      miscompares++; $display("FAIL mid_no_wb got x15=%h done=%b want 0/0", regValues[15], done);
    end
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] r;
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    f3  = 3'($urandom_range(0, 7));
    r   = $urandom();
    case ($urandom_range(0, 9))
      0: begin
        if (f3 == 3'd1 || f3 == 3'd5) f3 = 3'd0;
        return enc_i(r[11:0], rs1, f3, rd, 7'b0010011);
      end
      1: begin
        f3 = r[20] ? 3'd5 : 3'd1;
        f7 = (f3 == 3'd5 && r[21]) ? 7'h20 : 7'h00;
        return enc_r(f7, r[4:0], rs1, f3, rd, 7'b0010011);
      end
      2, 3: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00;
        return enc_r(f7, rs2, rs1, f3, rd, 7'b0110011);
      end
      4: return enc_u(r[19:0], rd, 7'b0110111);
      5: return enc_u(r[19:0], rd, 7'b0010111);
      6: return enc_j({r[20:1], 1'b0}, rd);
      7: return enc_i(r[11:0], rs1, 3'd0, rd, 7'b1100111);
      8: begin
        if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
        if (r[31]) rs2 = rs1;
        return enc_b({r[12:1], 1'b0}, rs2, rs1, f3);
      end
      default: begin
        case (r[1:0])
          2'd0: return {r[31:7], 7'b0000011};
          2'd1: return {r[31:7], 7'b0100011};
          2'd2: return {r[31:7], 7'b0001111};
          default: return {r[31:7], 7'b1110011};
        endcase
      end
    endcase
  endfunction

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      run_instr(rand_instr());
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_x0_lui();
    test_jump();
    test_branch();
    test_nop_classes();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
